// File: rtl/access_pkg.sv
// Shared constants for the split access controller (authentication + game).
// Holds the 4-bit state encoding, the reset password and small helpers.
package access_pkg;

  // Authentication controller states.
  localparam logic [3:0] S_DIGIT0  = 4'd0;
  localparam logic [3:0] S_DIGIT1  = 4'd1;
  localparam logic [3:0] S_DIGIT2  = 4'd2;
  localparam logic [3:0] S_DIGIT3  = 4'd3;
  localparam logic [3:0] S_VERIFY  = 4'd4;
  localparam logic [3:0] S_AUTH    = 4'd5;
  localparam logic [3:0] S_NEW0    = 4'd6;
  localparam logic [3:0] S_NEW1    = 4'd7;
  localparam logic [3:0] S_NEW2    = 4'd8;
  localparam logic [3:0] S_NEW3    = 4'd9;
  localparam logic [3:0] S_LOCKOUT = 4'd10;

  // Password loaded at reset; digit 0 lives in [15:12].
  localparam logic [15:0] DEFAULT_PW = 16'h1234;

  function automatic logic bcd_valid(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

  // Position of the digit expected in a given state; 0 outside entry states.
  function automatic logic [1:0] digit_pos(input logic [3:0] s);
    logic [1:0] p;
    p = 2'd0;
    if (s <= S_DIGIT3)                   p = s[1:0];
    else if (s >= S_NEW0 && s <= S_NEW3) p = 2'(s - S_NEW0);
    return p;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one history register and an AND gate.
// Ports: clk, rst (sync, active-low), d (level input), rise (d high now, low last cycle).
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst) prev <= 1'b0;
    else      prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/authentication_controller.sv
// Authentication controller: collects a 4-digit BCD password, compares it with
// the stored one and holds `enable` while authenticated. Consumes logout and
// password-change requests (rising-edge detected) from the game controller.
// Optional lockout after repeated failures is built when AUTH_LOCKOUT_EN is defined.
// Ports:
//   clk, rst (sync, active-low)
//   digit_in[3:0], enter     : digit entry (enter is a one-cycle pulse)
//   logout_s, passReset      : level requests from the game controller
//   enable                   : high while authenticated
//   auth_fail, pw_set        : one-cycle status pulses
//   digit_idx[1:0]           : digit position currently expected
//   locked                   : high during lockout (0 without AUTH_LOCKOUT_EN)
module authentication_controller #(
  parameter logic [15:0] DEFAULT_PW  = access_pkg::DEFAULT_PW,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic       enter,
  input  logic       logout_s,
  input  logic       passReset,
  output logic       enable,
  output logic       auth_fail,
  output logic       pw_set,
  output logic [1:0] digit_idx,
  output logic       locked
);
  import access_pkg::*;

  logic [3:0]  state, nxt;
  logic [15:0] entry, stored;
  logic        lo_rise, pr_rise;
  logic        dv, match, fail_hit;

  rise_detect u_logout (.clk(clk), .rst(rst), .d(logout_s),  .rise(lo_rise));
  rise_detect u_preset (.clk(clk), .rst(rst), .d(passReset), .rise(pr_rise));

  assign dv    = enter & bcd_valid(digit_in);
  assign match = (entry == stored);

`ifdef AUTH_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);
  localparam logic [LW-1:0] LOCK_END = LW'(LOCK_CYCLES - 1);

  logic [FW-1:0] fail_cnt;
  logic [LW-1:0] lock_cnt;

  assign fail_hit = (fail_cnt + FW'(1) == FAIL_MAX);
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(MAX_FAIL), 32'(LOCK_CYCLES)};
  assign fail_hit   = 1'b0;
  assign locked     = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_DIGIT0, S_DIGIT1, S_DIGIT2:
        if (dv) nxt = state + 4'd1;
      S_DIGIT3:
        if (dv) nxt = S_VERIFY;
      S_VERIFY:
        if (match)         nxt = S_AUTH;
        else if (fail_hit) nxt = S_LOCKOUT;
        else               nxt = S_DIGIT0;
      // Logout has priority; a simultaneous passReset edge is dropped.
      S_AUTH:
        if (lo_rise)      nxt = S_DIGIT0;
        else if (pr_rise) nxt = S_NEW0;
      S_NEW0, S_NEW1, S_NEW2:
        if (lo_rise) nxt = S_DIGIT0;
        else if (dv) nxt = state + 4'd1;
      S_NEW3:
        if (lo_rise || dv) nxt = S_DIGIT0;
`ifdef AUTH_LOCKOUT_EN
      S_LOCKOUT:
        if (lock_cnt == LOCK_END) nxt = S_DIGIT0;
`endif
      default: nxt = S_DIGIT0;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_DIGIT0;
      enable    <= 1'b0;
      auth_fail <= 1'b0;
      pw_set    <= 1'b0;
      digit_idx <= 2'd0;
      entry     <= 16'h0;
      stored    <= DEFAULT_PW;
    end else begin
      state     <= nxt;
      enable    <= (nxt == S_AUTH);
      digit_idx <= digit_pos(nxt);
      auth_fail <= (state == S_VERIFY) && !match;
      pw_set    <= 1'b0;
      if (dv && (state <= S_DIGIT3 || (state >= S_NEW0 && state <= S_NEW3))) begin
        case (digit_pos(state))
          2'd0: entry[15:12] <= digit_in;
          2'd1: entry[11:8]  <= digit_in;
          2'd2: entry[7:4]   <= digit_in;
          default: entry[3:0] <= digit_in;
        endcase
      end
      // Fourth new digit arrives this cycle, so merge it directly.
      if (state == S_NEW3 && dv && !lo_rise) begin
        stored <= {entry[15:4], digit_in};
        pw_set <= 1'b1;
      end
    end
  end

`ifdef AUTH_LOCKOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      fail_cnt <= '0;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      locked <= (nxt == S_LOCKOUT);
      if (state == S_VERIFY) begin
        if (match)                    fail_cnt <= '0;
        else if (fail_cnt != FAIL_MAX) fail_cnt <= fail_cnt + FW'(1);
      end
      if (state == S_LOCKOUT) begin
        if (lock_cnt == LOCK_END) begin
          lock_cnt <= '0;
          fail_cnt <= '0;
        end else begin
          lock_cnt <= lock_cnt + LW'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_authentication_controller.sv
// Directed self-checking bench for authentication_controller.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_authentication_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       enter = 1'b0;
  logic       logout_s = 1'b0;
  logic       passReset = 1'b0;
  logic       enable, auth_fail, pw_set, locked;
  logic [1:0] digit_idx;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  authentication_controller #(
    .DEFAULT_PW(16'h1234), .MAX_FAIL(3), .LOCK_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .enter(enter),
    .logout_s(logout_s), .passReset(passReset), .enable(enable),
    .auth_fail(auth_fail), .pw_set(pw_set), .digit_idx(digit_idx),
    .locked(locked)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One-cycle enter pulse; returns one cycle after the capturing edge.
  task automatic press(input logic [3:0] d);
    digit_in = d;
    enter    = 1'b1;
    tick();
    enter    = 1'b0;
  endtask

  // Four digits; returns in the VERIFY cycle (N+1).
  task automatic enter4(input logic [15:0] pw);
    press(pw[15:12]);
    press(pw[11:8]);
    press(pw[7:4]);
    press(pw[3:0]);
  endtask

  // Full entry followed by the verify cycle; returns at N+2.
  task automatic login(input logic [15:0] pw);
    enter4(pw);
    tick();
  endtask

  task automatic pulse_logout();
    logout_s = 1'b1;
    tick();
    logout_s = 1'b0;
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk("rst_enable", enable, 0);
    chk("rst_auth_fail", auth_fail, 0);
    chk("rst_pw_set", pw_set, 0);
    chk("rst_idx", digit_idx, 0);
    chk("rst_locked", locked, 0);
    rst = 1'b1;
    tick();

    // Correct entry, digit_idx stepping
    press(4'd1); chk("idx1", digit_idx, 1);
    press(4'd2); chk("idx2", digit_idx, 2);
    press(4'd3); chk("idx3", digit_idx, 3);
    press(4'd4); chk("idx_verify", digit_idx, 0);
    chk("enable_in_verify", enable, 0);
    tick();
    chk("login_enable", enable, 1);
    chk("login_no_fail", auth_fail, 0);

    // Held logout: one event only
    logout_s = 1'b1;
    tick();
    chk("logout_enable", enable, 0);
    repeat (49) tick();
    chk("logout_hold_enable", enable, 0);
    chk("logout_hold_idx", digit_idx, 0);
    login(16'h1234);
    chk("relogin_held", enable, 1);
    repeat (3) tick();
    chk("no_second_logout", enable, 1);
    logout_s = 1'b0;
    tick();

    // Mismatch then retry
    pulse_logout();
    chk("logout2_enable", enable, 0);
    enter4(16'h1235);
    tick();
    chk("bad_auth_fail", auth_fail, 1);
    chk("bad_enable", enable, 0);
    tick();
    chk("fail_pulse_width", auth_fail, 0);
    chk("fail_idx", digit_idx, 0);
    login(16'h1234);
    chk("retry_enable", enable, 1);

    // Password change
    passReset = 1'b1;
    tick();
    passReset = 1'b0;
    chk("preset_enable", enable, 0);
    chk("new0_idx", digit_idx, 0);
    press(4'd9); chk("new1_idx", digit_idx, 1);
    press(4'd8); press(4'd7);
    chk("new3_idx", digit_idx, 3);
    press(4'd6);
    chk("pw_set_pulse", pw_set, 1);
    chk("pw_set_enable", enable, 0);
    tick();
    chk("pw_set_width", pw_set, 0);
    enter4(16'h1234);
    tick();
    chk("old_pw_fails", auth_fail, 1);
    chk("old_pw_enable", enable, 0);
    tick();
    login(16'h9876);
    chk("new_pw_enable", enable, 1);

    // Simultaneous logout + passReset: logout wins
    logout_s = 1'b1; passReset = 1'b1;
    tick();
    logout_s = 1'b0; passReset = 1'b0;
    chk("both_enable", enable, 0);
    enter4(16'h9876);
    chk("both_no_pw_set", pw_set, 0);
    tick();
    chk("both_to_digit0", enable, 1);

    // Invalid digit in DIGIT1
    pulse_logout();
    press(4'd9);
    chk("bad_digit_pre", digit_idx, 1);
    press(4'hA);
    chk("bad_digit_idx", digit_idx, 1);
    press(4'd8); press(4'd7); press(4'd6);
    tick();
    chk("bad_digit_login", enable, 1);

    // Abort during NEW*: password unchanged
    passReset = 1'b1;
    tick();
    passReset = 1'b0;
    press(4'd1); press(4'd1);
    chk("abort_pre_idx", digit_idx, 2);
    pulse_logout();
    chk("abort_idx", digit_idx, 0);
    chk("abort_pw_set", pw_set, 0);
    login(16'h9876);
    chk("abort_keeps_pw", enable, 1);

    // Reset mid-entry restores default password
    pulse_logout();
    press(4'd9); press(4'd8);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_idx", digit_idx, 0);
    chk("midrst_enable", enable, 0);
    login(16'h1234);
    chk("midrst_default_pw", enable, 1);

    // Repeated failures
    rst = 1'b0;
    tick();
    rst = 1'b1;
    login(16'h0000); tick();
    login(16'h0000); tick();
    enter4(16'h0000);
    tick();
    chk("third_fail_pulse", auth_fail, 1);
`ifdef AUTH_LOCKOUT_EN
    chk("lock_first", locked, 1);
    for (int i = 1; i < 20; i++) begin
      if (i == 5) begin
        digit_in = 4'd1; enter = 1'b1;
      end
      tick();
      enter = 1'b0;
      if (locked !== 1'b1) chk("lock_held", locked, 1);
      else n_checks++;
    end
    chk("lock_idx", digit_idx, 0);
    tick();
    chk("lock_released", locked, 0);
    chk("lock_release_idx", digit_idx, 0);
    login(16'h1234);
    chk("post_lock_login", enable, 1);
`else
    chk("no_lock", locked, 0);
    tick();
    chk("no_lock_idx", digit_idx, 0);
    login(16'h1234);
    chk("no_lock_login", enable, 1);
    chk("no_lock_locked", locked, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
